// File: rtl/qam16_pkg.sv
// rtl/qam16_pkg.sv - shared QAM16 level codes, state encoding and default constants
package qam16_pkg;

  // Gray level codes per axis, shared with the transmit symbol mapper
  localparam logic [1:0] LVL_M3 = 2'b00;
  localparam logic [1:0] LVL_M1 = 2'b01;
  localparam logic [1:0] LVL_P1 = 2'b11;
  localparam logic [1:0] LVL_P3 = 2'b10;

  // Receiver state encoding
  localparam logic [1:0] ST_ACQ   = 2'd0;
  localparam logic [1:0] ST_PICK  = 2'd1;
  localparam logic [1:0] ST_TRACK = 2'd2;

  // Default link constants
  localparam int                 DEF_SPS      = 4;
  localparam int                 DEF_ACQ_SYMS = 64;
  localparam logic signed [15:0] DEF_THRESH   = 16'sd2048;

  // Magnitude of a 16-bit sample; the most negative value clips to 32767
  function automatic logic [15:0] abs_sat(input logic signed [15:0] x);
    if (x == 16'sh8000)
      return 16'd32767;
    else if (x < 16'sd0)
      return unsigned'(-x);
    else
      return unsigned'(x);
  endfunction

endpackage

// File: rtl/qam16_slicer.sv
// rtl/qam16_slicer.sv - single-axis 4-level decision slicer
module qam16_slicer
  import qam16_pkg::*;
#(
  parameter logic signed [15:0] THRESH = DEF_THRESH
) (
  input  logic signed [15:0] x,
  output logic        [1:0]  code
);

  localparam logic signed [15:0] NTHRESH = -THRESH;

  // Decide the nearest level; zero goes to +1 and exactly +/-THRESH go to the outer levels
  always_comb begin
    code = LVL_P3;
    if (x <= NTHRESH)
      code = LVL_M3;
    else if (x < 16'sd0)
      code = LVL_M1;
    else if (x < THRESH)
      code = LVL_P1;
  end

endmodule

// File: rtl/qam16_rx_demod.sv
// rtl/qam16_rx_demod.sv - QAM16 symbol timing acquisition and demapper
module qam16_rx_demod
  import qam16_pkg::*;
#(
  parameter int                 SPS      = DEF_SPS,
  parameter int                 ACQ_SYMS = DEF_ACQ_SYMS,
  parameter logic signed [15:0] THRESH   = DEF_THRESH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din_valid,
  input  logic signed [15:0] din_i,
  input  logic signed [15:0] din_q,
  input  logic               resync,
  output logic        [3:0]  sym_data,
  output logic               sym_valid,
  output logic               locked,
  output logic        [3:0]  sym_phase
);

  localparam int PW   = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int NACQ = ACQ_SYMS * SPS;
  localparam int CW   = $clog2(NACQ) + 1;

  localparam logic [PW-1:0] PH_LAST  = PW'(SPS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NACQ - 1);

  logic [PW-1:0] phase;
  logic [1:0]    state;
  logic [23:0]   acc [SPS];
  logic [CW-1:0] cnt;
  logic [PW-1:0] scan_idx;
  logic [PW-1:0] best_idx;
  logic [23:0]   best_val;
  logic [PW-1:0] sel_phase;
  logic [16:0]   mag;
  logic          scan_win;
  logic [1:0]    code_i;
  logic [1:0]    code_q;

  // Per-sample energy estimate used to find the eye opening
  assign mag      = {1'b0, abs_sat(din_i)} + {1'b0, abs_sat(din_q)};
  // Strictly greater keeps the earliest phase on ties
  assign scan_win = acc[scan_idx] > best_val;
  assign sym_phase = 4'(sel_phase);

  qam16_slicer #(.THRESH(THRESH)) u_slice_i (
    .x    (din_i),
    .code (code_i)
  );

  qam16_slicer #(.THRESH(THRESH)) u_slice_q (
    .x    (din_q),
    .code (code_q)
  );

  // Free-running sample phase; only reset clears it so resync keeps timing continuity
  always_ff @(posedge clk) begin
    if (reset)
      phase <= '0;
    else if (din_valid)
      phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
  end

  // Acquisition, phase pick and tracking state machine
  always_ff @(posedge clk) begin
    if (reset || resync) begin
      state     <= ST_ACQ;
      cnt       <= '0;
      locked    <= 1'b0;
      sym_valid <= 1'b0;
      scan_idx  <= '0;
      best_idx  <= '0;
      best_val  <= '0;
      for (int k = 0; k < SPS; k++)
        acc[k] <= '0;
      if (reset) begin
        sel_phase <= '0;
        sym_data  <= 4'b0000;
      end
    end else begin
      sym_valid <= 1'b0;
      case (state)
        ST_ACQ: begin
          if (din_valid) begin
            acc[phase] <= acc[phase] + {7'd0, mag};
            cnt        <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state    <= ST_PICK;
              scan_idx <= '0;
              best_idx <= '0;
              best_val <= '0;
            end
          end
        end
        ST_PICK: begin
          if (scan_win) begin
            best_val <= acc[scan_idx];
            best_idx <= scan_idx;
          end
          if (scan_idx == PH_LAST) begin
            state     <= ST_TRACK;
            sel_phase <= scan_win ? scan_idx : best_idx;
            locked    <= 1'b1;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        ST_TRACK: begin
          if (din_valid && (phase == sel_phase)) begin
            sym_valid <= 1'b1;
            sym_data  <= {code_i, code_q};
          end
        end
        default: state <= ST_ACQ;
      endcase
    end
  end

endmodule

// File: tb/tb_qam16_rx_demod.sv
// tb/tb_qam16_rx_demod.sv - scoreboard bench for qam16_rx_demod
module tb_qam16_rx_demod;

  logic               clk;
  logic               reset;
  logic               din_valid;
  logic signed [15:0] din_i;
  logic signed [15:0] din_q;
  logic               resync;
  logic        [3:0]  sym_data;
  logic               sym_valid;
  logic               locked;
  logic        [3:0]  sym_phase;

  int n_cmp;
  int n_err;
  int n_push;
  int n_strobe;
  int ph;
  int trk_phase;
  bit trk;
  bit hold_en;
  logic [3:0] last_exp;
  logic [3:0] exp_q [$];

  qam16_rx_demod dut (
    .clk       (clk),
    .reset     (reset),
    .din_valid (din_valid),
    .din_i     (din_i),
    .din_q     (din_q),
    .resync    (resync),
    .sym_data  (sym_data),
    .sym_valid (sym_valid),
    .locked    (locked),
    .sym_phase (sym_phase)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One input cycle; expected symbol is queued when the model says it lands on the lock phase
  task automatic drive(input logic signed [15:0] i, input logic signed [15:0] q,
                       input logic v, input logic rs, input logic [3:0] e);
    @(negedge clk);
    din_valid = v;
    din_i     = i;
    din_q     = q;
    resync    = rs;
    if (v) begin
      if (trk && !rs && ph == trk_phase) begin
        exp_q.push_back(e);
        n_push++;
      end
      ph = (ph + 1) % 4;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(16'sd0, 16'sd0, 1'b0, 1'b0, 4'b0000);
  endtask

  // One symbol period: data at the lock phase, zeros elsewhere
  task automatic send_sym(input logic signed [15:0] i, input logic signed [15:0] q,
                          input logic [3:0] e, input bit gap);
    for (int k = 0; k < 4; k++) begin
      if (ph == trk_phase)
        drive(i, q, 1'b1, 1'b0, e);
      else
        drive(16'sd0, 16'sd0, 1'b1, 1'b0, 4'b1111);
      if (gap) idle(1);
    end
  endtask

  // 256 valid samples with I=Q=e<phase>
  task automatic acq(input logic signed [15:0] e0, input logic signed [15:0] e1,
                     input logic signed [15:0] e2, input logic signed [15:0] e3);
    logic signed [15:0] v;
    for (int n = 0; n < 256; n++) begin
      v = (ph == 0) ? e0 : (ph == 1) ? e1 : (ph == 2) ? e2 : e3;
      drive(v, v, 1'b1, 1'b0, 4'b0000);
    end
  endtask

  task automatic pick_check(input int p);
    idle(4);
    chk("locked_before_pick_done", int'(locked), 0);
    idle(1);
    chk("locked_after_pick", int'(locked), 1);
    chk("sym_phase", int'(sym_phase), p);
    trk       = 1'b1;
    trk_phase = p;
  endtask

  // Scoreboard monitor, sampling just after each rising edge
  always @(posedge clk) begin
    #1;
    if (sym_valid) begin
      n_strobe++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_sym_valid: got sym_data %b with no symbol expected", sym_data);
      end else begin
        last_exp = exp_q.pop_front();
        if (sym_data !== last_exp) begin
          n_err++;
          $display("FAIL sym_data: got %b expected %b", sym_data, last_exp);
        end
      end
    end else if (hold_en) begin
      n_cmp++;
      if (sym_data !== last_exp) begin
        n_err++;
        $display("FAIL sym_data_hold: got %b expected %b", sym_data, last_exp);
      end
    end
  end

  initial begin
    n_cmp = 0; n_err = 0; n_push = 0; n_strobe = 0;
    ph = 0; trk = 1'b0; trk_phase = 0; hold_en = 1'b0; last_exp = 4'b0000;
    reset = 1'b1; din_valid = 1'b0; din_i = '0; din_q = '0; resync = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_locked", int'(locked), 0);
    chk("reset_sym_valid", int'(sym_valid), 0);
    chk("reset_sym_phase", int'(sym_phase), 0);
    chk("reset_sym_data", int'(sym_data), 0);
    reset    = 1'b0;
    last_exp = 4'b0000;
    hold_en  = 1'b1;

    // Energy only at phase 2
    acq(16'sd0, 16'sd0, 16'sd3000, 16'sd0);
    pick_check(2);

    // Decisions including threshold and zero boundaries
    send_sym(-16'sd3000,  16'sd500,   4'b0011, 1'b0);
    send_sym( 16'sd0,     16'sd2048,  4'b1110, 1'b0);
    send_sym(-16'sd2048, -16'sd1,     4'b0001, 1'b0);
    send_sym( 16'sd3000, -16'sd3000,  4'b1000, 1'b0);
    send_sym( 16'sd2047, -16'sd2047,  4'b1101, 1'b0);
    send_sym(16'sh8000,   16'sd32767, 4'b0010, 1'b0);

    // din_valid toggling 1-0-1
    send_sym(-16'sd2049,  16'sd2049,  4'b0010, 1'b1);
    send_sym( 16'sd1,    -16'sd2047,  4'b1101, 1'b1);
    send_sym(-16'sd1,     16'sd0,     4'b0111, 1'b1);

    // resync on a matching-phase sample suppresses it
    while (ph != trk_phase) drive(16'sd0, 16'sd0, 1'b1, 1'b0, 4'b1111);
    drive(16'sd3000, 16'sd3000, 1'b1, 1'b1, 4'b0000);
    trk = 1'b0;
    idle(1);
    chk("locked_after_resync", int'(locked), 0);

    // Equal energy at phases 1 and 3
    acq(16'sd0, 16'sd3000, 16'sd0, 16'sd3000);
    pick_check(1);
    send_sym(16'sd3000, 16'sd3000, 4'b1010, 1'b0);

    // Full-scale negative at every phase
    drive(16'sd0, 16'sd0, 1'b0, 1'b1, 4'b0000);
    trk = 1'b0;
    acq(16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000);
    pick_check(0);
    send_sym(16'sh8000, 16'sh8000, 4'b0000, 1'b0);

    // Reset in the middle of tracking
    @(negedge clk);
    hold_en = 1'b0;
    reset = 1'b1; din_valid = 1'b1; din_i = 16'sd3000; din_q = 16'sd3000; resync = 1'b0;
    @(negedge clk);
    reset = 1'b0; din_valid = 1'b0;
    chk("midreset_locked", int'(locked), 0);
    chk("midreset_sym_valid", int'(sym_valid), 0);
    chk("midreset_sym_phase", int'(sym_phase), 0);
    chk("midreset_sym_data", int'(sym_data), 0);
    ph = 0; trk = 1'b0; last_exp = 4'b0000; hold_en = 1'b1;
    repeat (16) drive(16'sd3000, 16'sd3000, 1'b1, 1'b0, 4'b0000);
    idle(3);

    chk("queue_empty", exp_q.size(), 0);
    chk("strobe_count", n_strobe, n_push);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
